// File: rtl/harmonic_sequencer.sv
// Frame controller for additive synthesis: walks harmonic indices once per output
// sample, hands each one to an accumulating adder in turn, then paces the DAC transfer.
module harmonic_sequencer #(
    parameter int NUM_ADDERS      = 2,
    parameter int HARM_W          = 8,
    parameter int MAX_HARMONICS   = 50,
    parameter int SAMPLE_INTERVAL = 1000
) (
    input  logic                  Main_Clock,
    input  logic                  Reset,
    input  logic [HARM_W-1:0]     i_Harmonic_Count,
    input  logic                  i_Sample_Ready,
    input  logic                  i_Freq_Too_High,
    output logic                  o_Next_Sample,
    output logic [HARM_W-1:0]     o_Harmonic,
    output logic [NUM_ADDERS-1:0] o_Adder_Start,
    input  logic [NUM_ADDERS-1:0] i_Adder_Ready,
    output logic                  o_Adder_Clear,
    output logic                  o_Latch_Totals,
    output logic                  o_Mult_Start,
    output logic                  o_Mult_Restart,
    input  logic                  i_Mult_Ready,
    input  logic                  i_Comb_Muted,
    output logic                  o_DAC_Send,
    output logic                  o_Overrun
);

    localparam int TMR_W    = (SAMPLE_INTERVAL > 1) ? $clog2(SAMPLE_INTERVAL) : 1;
    localparam int CEIL_INT = (MAX_HARMONICS < (1 << HARM_W)) ? MAX_HARMONICS : (1 << HARM_W) - 1;

    localparam logic [TMR_W-1:0]  TICK_AT    = TMR_W'(SAMPLE_INTERVAL - 1);
    localparam logic [HARM_W-1:0] LAST_CEIL  = HARM_W'(CEIL_INT);
    localparam logic [HARM_W-1:0] HARM_TOP   = '1;
    localparam logic [HARM_W-1:0] ADDER_MASK = HARM_W'(NUM_ADDERS - 1);

    typedef enum logic [3:0] {
        INIT, ADD_START, ADD_WAIT, NEXT, MULT, CHECK_MUTE, DRAIN, LATCH, CLEAR, WAIT_TICK
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [TMR_W-1:0]        r_timer;
    logic [HARM_W-1:0]       r_harmonic;
    logic [HARM_W-1:0]       r_last;
    logic                    r_abort;
    logic                    r_overrun;
    logic [NUM_ADDERS-1:0]   r_adder_start;
    logic                    r_next_sample;
    logic                    r_mult_start;
    logic                    r_mult_restart;
    logic                    r_latch_totals;
    logic                    r_adder_clear;
    logic                    r_dac_send;

    logic                    w_tick;
    logic                    w_tick_overrun;
    logic [NUM_ADDERS-1:0]   w_sel;
    logic                    w_add_go;
    logic                    w_harm_sat;
    logic                    w_frame_done;
    logic [HARM_W-1:0]       w_last_clamped;
    logic [NUM_ADDERS-1:0]   w_start_nxt;
    logic                    w_next_samp_nxt;
    logic                    w_mult_start_nxt;
    logic                    w_latch_nxt;
    logic                    w_clear_nxt;
    logic                    w_frame_end;
    logic                    w_harm_inc;

    // Free-running sample timer; the tick marks the last cycle of each interval.
    assign w_tick         = (r_timer == TICK_AT);
    assign w_tick_overrun = w_tick && (r_state != WAIT_TICK);

    // Harmonics go round-robin over the adders, so the low index bits pick one.
    assign w_sel          = NUM_ADDERS'(1) << (r_harmonic & ADDER_MASK);
    assign w_add_go       = i_Sample_Ready && |(i_Adder_Ready & w_sel);
    assign w_harm_sat     = (r_harmonic == HARM_TOP);
    assign w_frame_done   = (r_harmonic >= r_last) || i_Freq_Too_High || w_harm_sat;
    assign w_last_clamped = (i_Harmonic_Count > LAST_CEIL) ? LAST_CEIL : i_Harmonic_Count;

    always_ff @(posedge Main_Clock) begin
        if (Reset || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TMR_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            INIT:       w_next_state = ADD_START;
            ADD_START: begin
                if (r_abort)       w_next_state = DRAIN;
                else if (w_add_go) w_next_state = ADD_WAIT;
            end
            ADD_WAIT:   w_next_state = NEXT;
            NEXT:       w_next_state = (r_abort || w_frame_done) ? DRAIN : MULT;
            MULT:       w_next_state = r_abort ? DRAIN : CHECK_MUTE;
            CHECK_MUTE: begin
                if (r_abort)           w_next_state = DRAIN;
                else if (i_Mult_Ready) w_next_state = i_Comb_Muted ? NEXT : ADD_START;
            end
            DRAIN:      if (&i_Adder_Ready) w_next_state = LATCH;
            LATCH:      w_next_state = CLEAR;
            CLEAR:      w_next_state = WAIT_TICK;
            WAIT_TICK:  if (w_tick || r_abort) w_next_state = INIT;
            default:    w_next_state = INIT;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        w_start_nxt      = '0;
        w_next_samp_nxt  = 1'b0;
        w_mult_start_nxt = 1'b0;
        w_latch_nxt      = 1'b0;
        w_clear_nxt      = 1'b0;
        w_frame_end      = 1'b0;
        w_harm_inc       = 1'b0;
        case (r_state)
            ADD_START: begin
                if (!r_abort && w_add_go) w_start_nxt = w_sel;
            end
            NEXT: begin
                if (!r_abort && !w_harm_sat) begin
                    w_harm_inc      = 1'b1;
                    w_next_samp_nxt = 1'b1;
                end
            end
            MULT:      w_mult_start_nxt = !r_abort;
            LATCH:     w_latch_nxt      = 1'b1;
            CLEAR:     w_clear_nxt      = 1'b1;
            WAIT_TICK: begin
                if (w_tick || r_abort) begin
                    w_frame_end     = 1'b1;
                    w_next_samp_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Pulses are registered so every output is glitch-free and cleared by reset.
    always_ff @(posedge Main_Clock) begin
        if (Reset) begin
            r_harmonic     <= '0;
            r_last         <= '0;
            r_abort        <= 1'b0;
            r_overrun      <= 1'b0;
            r_adder_start  <= '0;
            r_next_sample  <= 1'b0;
            r_mult_start   <= 1'b0;
            r_mult_restart <= 1'b0;
            r_latch_totals <= 1'b0;
            r_adder_clear  <= 1'b0;
            r_dac_send     <= 1'b0;
        end else begin
            r_adder_start  <= w_start_nxt;
            r_next_sample  <= w_next_samp_nxt;
            r_mult_start   <= w_mult_start_nxt;
            r_mult_restart <= w_frame_end;
            r_latch_totals <= w_latch_nxt;
            r_adder_clear  <= w_clear_nxt;
            r_dac_send     <= w_frame_end;

            if (r_state == INIT) begin
                r_last <= w_last_clamped;
            end

            if (w_frame_end) begin
                r_harmonic <= '0;
            end else if (w_harm_inc) begin
                r_harmonic <= r_harmonic + HARM_W'(1);
            end

            // A late frame aborts; the sticky flag survives until reset.
            if (w_frame_end) begin
                r_abort <= 1'b0;
            end else if (w_tick_overrun) begin
                r_abort <= 1'b1;
            end
            if (w_tick_overrun) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign o_Next_Sample  = r_next_sample;
    assign o_Harmonic     = r_harmonic;
    assign o_Adder_Start  = r_adder_start;
    assign o_Adder_Clear  = r_adder_clear;
    assign o_Latch_Totals = r_latch_totals;
    assign o_Mult_Start   = r_mult_start;
    assign o_Mult_Restart = r_mult_restart;
    assign o_DAC_Send     = r_dac_send;
    assign o_Overrun      = r_overrun;

endmodule

// File: tb/tb_harmonic_sequencer.sv
// Bench for harmonic_sequencer: directed and randomized frames compared against a
// harmonic-walk reference model, plus overrun, mid-frame reset and four-adder cases.
module tb_harmonic_sequencer;

    localparam int HW = 8;

    logic          Main_Clock = 1'b0;
    logic          Reset;
    logic [HW-1:0] harm_count;
    logic          sample_ready;
    logic          freq_too_high;
    logic          mult_ready;
    logic          comb_muted;
    logic [1:0]    adder_ready_a;
    logic [3:0]    adder_ready_b;

    logic          a_next, a_clear, a_latch, a_mstart, a_restart, a_dac, a_overrun;
    logic [HW-1:0] a_harm;
    logic [1:0]    a_start;
    logic          b_next, b_clear, b_latch, b_mstart, b_restart, b_dac, b_overrun;
    logic [HW-1:0] b_harm;
    logic [3:0]    b_start;

    always #5 Main_Clock = ~Main_Clock;

    harmonic_sequencer #(.NUM_ADDERS(2)) u_dut_a (
        .Main_Clock(Main_Clock), .Reset(Reset), .i_Harmonic_Count(harm_count),
        .i_Sample_Ready(sample_ready), .i_Freq_Too_High(freq_too_high),
        .o_Next_Sample(a_next), .o_Harmonic(a_harm), .o_Adder_Start(a_start),
        .i_Adder_Ready(adder_ready_a), .o_Adder_Clear(a_clear), .o_Latch_Totals(a_latch),
        .o_Mult_Start(a_mstart), .o_Mult_Restart(a_restart), .i_Mult_Ready(mult_ready),
        .i_Comb_Muted(comb_muted), .o_DAC_Send(a_dac), .o_Overrun(a_overrun)
    );

    harmonic_sequencer #(.NUM_ADDERS(4)) u_dut_b (
        .Main_Clock(Main_Clock), .Reset(Reset), .i_Harmonic_Count(harm_count),
        .i_Sample_Ready(sample_ready), .i_Freq_Too_High(freq_too_high),
        .o_Next_Sample(b_next), .o_Harmonic(b_harm), .o_Adder_Start(b_start),
        .i_Adder_Ready(adder_ready_b), .o_Adder_Clear(b_clear), .o_Latch_Totals(b_latch),
        .o_Mult_Start(b_mstart), .o_Mult_Restart(b_restart), .i_Mult_Ready(mult_ready),
        .i_Comb_Muted(comb_muted), .o_DAC_Send(b_dac), .o_Overrun(b_overrun)
    );

    int          n_vec  = 0;
    int          n_miss = 0;

    // Stub configuration.
    bit          instant;
    bit          mult_hold;
    logic [63:0] mute_mask;
    int          fth;
    int          busy_a [2];

    // Per-frame observations.
    int          a_start_h [$];
    int          a_start_v [$];
    int          b_start_v [$];
    int          latch_cnt, clear_cnt, onehot_err, final_h, cyc, dac_cyc, next_dac;
    bit          dac_seen, restart_at_dac, overrun_at_dac;

    // Reference model output.
    int          exp_h [$];
    int          exp_v [$];
    int          exp_final;

    task automatic check(input string tag, input int obs, input int exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Walk harmonics 0..Last: harmonic 0 always reaches an adder, later ones only
    // when not muted; the walk stops after the last index or the first too-high one.
    function automatic void build_model(input int count, input logic [63:0] mute, input int th);
        int last;
        last = (count > 50) ? 50 : count;
        exp_h.delete();
        exp_v.delete();
        exp_final = -1;
        for (int h = 0; h < 256; h++) begin
            if (h == 0 || !(h < 64 && mute[h])) begin
                exp_h.push_back(h);
                exp_v.push_back(1 << (h % 2));
            end
            if (h >= last || h >= th || h == 255) begin
                exp_final = (h == 255) ? 255 : h + 1;
                break;
            end
        end
    endfunction

    task automatic set_frame(input int count, input logic [63:0] mute, input int th);
        harm_count = HW'(count);
        mute_mask  = mute;
        fth        = th;
        build_model(count, mute, th);
    endtask

    // One clock: observe at the falling edge, then update stub inputs.
    task automatic cycle();
        @(negedge Main_Clock);
        cyc++;
        for (int k = 0; k < 2; k++) if (busy_a[k] > 0) busy_a[k]--;
        if (a_start != 2'b00) begin
            a_start_h.push_back(int'(a_harm));
            a_start_v.push_back(int'(a_start));
            for (int k = 0; k < 2; k++)
                if (a_start[k]) busy_a[k] = instant ? 0 : int'($urandom_range(0, 3));
        end
        if (b_start != 4'b0000) b_start_v.push_back(int'(b_start));
        if ($countones(a_start) > 1 || $countones(b_start) > 1) onehot_err++;
        if (a_latch) begin
            latch_cnt++;
            final_h = int'(a_harm);
        end
        if (a_clear) clear_cnt++;
        if (a_dac && !dac_seen) begin
            dac_seen       = 1'b1;
            dac_cyc        = cyc;
            restart_at_dac = a_restart;
            overrun_at_dac = a_overrun;
        end
        for (int k = 0; k < 2; k++) adder_ready_a[k] = (busy_a[k] == 0);
        sample_ready  = instant ? 1'b1 : ($urandom_range(0, 3) != 0);
        mult_ready    = mult_hold ? 1'b0 : (instant ? 1'b1 : ($urandom_range(0, 3) != 0));
        comb_muted    = (a_harm < HW'(64)) ? mute_mask[a_harm[5:0]] : 1'b0;
        freq_too_high = (int'(a_harm) >= fth);
    endtask

    task automatic run_frame(input string tag, input int budget);
        a_start_h.delete();
        a_start_v.delete();
        b_start_v.delete();
        latch_cnt  = 0;
        clear_cnt  = 0;
        onehot_err = 0;
        final_h    = -1;
        dac_seen   = 1'b0;
        for (int i = 0; i < budget && !dac_seen; i++) cycle();
        check({tag, " dac_seen"}, int'(dac_seen), 1);
    endtask

    task automatic compare_frame(input string tag, input int exp_ovr);
        check({tag, " n_starts"}, a_start_v.size(), exp_v.size());
        for (int i = 0; i < exp_v.size() && i < a_start_v.size(); i++) begin
            check($sformatf("%s start_vec[%0d]", tag, i), a_start_v[i], exp_v[i]);
            check($sformatf("%s start_harm[%0d]", tag, i), a_start_h[i], exp_h[i]);
        end
        check({tag, " final_harm"}, final_h, exp_final);
        check({tag, " latch_cnt"}, latch_cnt, 1);
        check({tag, " clear_cnt"}, clear_cnt, 1);
        check({tag, " onehot"}, onehot_err, 0);
        check({tag, " restart_with_dac"}, int'(restart_at_dac), 1);
        check({tag, " overrun"}, int'(overrun_at_dac), exp_ovr);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " a_pulses"},
              int'({a_next, a_start, a_clear, a_latch, a_mstart, a_restart, a_dac}), 0);
        check({tag, " a_harm"}, int'(a_harm), 0);
        check({tag, " a_overrun"}, int'(a_overrun), 0);
        check({tag, " b_outputs"},
              int'({b_next, b_start, b_clear, b_latch, b_mstart, b_restart, b_dac,
                    b_overrun, b_harm}), 0);
    endtask

    task automatic do_reset(input string tag);
        Reset         = 1'b1;
        busy_a        = '{0, 0};
        adder_ready_a = 2'b11;
        cycle();
        cycle();
        check_idle(tag);
        Reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        bit          seen;
        int          cnt, th;
        logic [63:0] mm;

        Reset         = 1'b1;
        harm_count    = '0;
        sample_ready  = 1'b1;
        freq_too_high = 1'b0;
        mult_ready    = 1'b1;
        comb_muted    = 1'b0;
        adder_ready_a = 2'b11;
        adder_ready_b = 4'hF;
        instant       = 1'b1;
        mult_hold     = 1'b0;
        busy_a        = '{0, 0};
        cyc           = 0;

        // Instant stubs, two adders, Last = 4: starts 0,1,0,1,0; DAC every 1000 cycles.
        set_frame(4, 64'd0, 999);
        do_reset("reset");
        run_frame("basic", 1100);
        compare_frame("basic", 0);
        check("basic dac_cyc", dac_cyc, 1000);
        run_frame("basic2", 1100);
        compare_frame("basic2", 0);
        check("basic2 dac_cyc", dac_cyc, 2000);
        next_dac = 3000;

        // Harmonics 2 and 3 muted: no adder for them, index still reaches 5.
        set_frame(4, (64'd1 << 2) | (64'd1 << 3), 999);
        run_frame("mute", 1100);
        compare_frame("mute", 0);
        check("mute dac_cyc", dac_cyc, next_dac);
        next_dac += 1000;

        // Above Nyquist from harmonic 3 with Last = 50: walk stops after harmonic 3.
        set_frame(50, 64'd0, 3);
        run_frame("nyquist", 1100);
        compare_frame("nyquist", 0);
        check("nyquist dac_cyc", dac_cyc, next_dac);
        next_dac += 1000;

        // Four adders, Last = 7: one-hot starts rotate 1,2,4,8,1,2,4,8.
        set_frame(7, 64'd0, 999);
        run_frame("four", 1100);
        check("four n_starts", b_start_v.size(), 8);
        for (int i = 0; i < 8 && i < b_start_v.size(); i++)
            check($sformatf("four start_vec[%0d]", i), b_start_v[i], 1 << (i % 4));
        check("four dac_cyc", dac_cyc, next_dac);
        next_dac += 1000;

        // Randomized frames: busy adders, slow ready stubs, random mute and Nyquist cut.
        instant = 1'b0;
        for (int f = 0; f < 6; f++) begin
            cnt = (f == 2) ? 200 : int'($urandom_range(0, 60));
            mm  = {$urandom, $urandom} & {$urandom, $urandom};
            th  = ($urandom_range(0, 1) == 1) ? 999 : int'($urandom_range(0, 20));
            set_frame(cnt, mm, th);
            run_frame($sformatf("rand%0d", f), 1100);
            compare_frame($sformatf("rand%0d", f), 0);
            check($sformatf("rand%0d dac_cyc", f), dac_cyc, next_dac);
            next_dac += 1000;
        end

        // Reset while waiting in CHECK_MUTE: outputs clear, no DAC until the first tick.
        instant   = 1'b1;
        mult_hold = 1'b1;
        mult_ready = 1'b0;
        set_frame(4, 64'd0, 999);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            cycle();
            if (a_mstart) seen = 1'b1;
        end
        check("midreset reached_check_mute", int'(seen), 1);
        Reset = 1'b1;
        cycle();
        check_idle("midreset");
        Reset      = 1'b0;
        cyc        = 0;
        mult_hold  = 1'b0;
        mult_ready = 1'b1;
        run_frame("midreset", 1100);
        compare_frame("midreset", 0);
        check("midreset dac_cyc", dac_cyc, 1000);

        // Adder 1 busy for 1200 cycles: tick in ADD_START aborts, DRAIN waits,
        // DAC goes out right after CLEAR without waiting for a second tick.
        set_frame(4, 64'd0, 999);
        do_reset("ovr_reset");
        busy_a[1]        = 1200;
        adder_ready_a[1] = 1'b0;
        run_frame("overrun", 2500);
        check("overrun n_starts", a_start_v.size(), 1);
        if (a_start_v.size() > 0) check("overrun start_vec", a_start_v[0], 1);
        check("overrun flag", int'(overrun_at_dac), 1);
        check("overrun latch_cnt", latch_cnt, 1);
        check("overrun clear_cnt", clear_cnt, 1);
        check("overrun dac_after_drain", int'(dac_cyc > 1200 && dac_cyc < 1210), 1);
        run_frame("post_ovr", 1100);
        compare_frame("post_ovr", 1);
        check("post_ovr dac_cyc", dac_cyc, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/harmonic_sequencer.md
HARMONIC_SEQUENCER -- requirements
Module: harmonic_sequencer

Interface
REQ-001 SHALL have parameter NUM_ADDERS, default 2, meaning the number of accumulating adders (power of 2, range 1..8).
REQ-002 SHALL have parameter HARM_W, default 8, meaning the harmonic index width.
REQ-003 SHALL have parameter MAX_HARMONICS, default 50, meaning the hard ceiling on the last harmonic index.
REQ-004 SHALL have parameter SAMPLE_INTERVAL, default 1000, meaning Main_Clock cycles per output sample.
REQ-005 Main_Clock  in  1  system clock; all logic on its rising edge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 i_Harmonic_Count  in  HARM_W  runtime last harmonic index, sampled at frame start.
REQ-008 i_Sample_Ready  in  1  sine value for o_Harmonic is valid.
REQ-009 i_Freq_Too_High  in  1  current harmonic is above Nyquist.
REQ-010 o_Next_Sample  out  1  one-cycle pulse requesting the next sine lookup.
REQ-011 o_Harmonic  out  HARM_W  harmonic index being processed.
REQ-012 o_Adder_Start  out  NUM_ADDERS  one-hot, one-cycle start per adder.
REQ-013 i_Adder_Ready  in  NUM_ADDERS  per-adder idle flags.
REQ-014 o_Adder_Clear  out  1  one-cycle accumulator clear.
REQ-015 o_Latch_Totals  out  1  one-cycle pulse; downstream captures all adder totals.
REQ-016 o_Mult_Start / o_Mult_Restart  out  1 each  scaler step / scaler reload pulses.
REQ-017 i_Mult_Ready, i_Comb_Muted  in  1 each  scaler done flag / current harmonic muted.
REQ-018 o_DAC_Send  out  1  one-cycle pulse starting the DAC transfer.
REQ-019 o_Overrun  out  1  sticky flag: a frame did not finish within SAMPLE_INTERVAL.

Function
REQ-020 Timer SHALL count 0..SAMPLE_INTERVAL-1 free-running; "tick" = count equals SAMPLE_INTERVAL-1; the counter wraps to 0 on the following cycle.
REQ-021 States SHALL be INIT, ADD_START, ADD_WAIT, NEXT, MULT, CHECK_MUTE, DRAIN, LATCH, CLEAR, WAIT_TICK.
REQ-022 INIT: clear all pulses, latch Last = min(i_Harmonic_Count, MAX_HARMONICS), go to ADD_START.
REQ-023 ADD_START: when i_Sample_Ready and i_Adder_Ready[o_Harmonic mod NUM_ADDERS], pulse that start bit, go to ADD_WAIT; otherwise hold.
REQ-024 ADD_WAIT: single cycle, go to NEXT.
REQ-025 NEXT: increment o_Harmonic, pulse o_Next_Sample; go to DRAIN if the old o_Harmonic >= Last or i_Freq_Too_High, else go to MULT.
REQ-026 MULT: pulse o_Mult_Start, go to CHECK_MUTE.
REQ-027 CHECK_MUTE: wait for i_Mult_Ready; go to NEXT if i_Comb_Muted (adder skipped), else go to ADD_START.
REQ-028 DRAIN: wait until all i_Adder_Ready bits are 1, then go to LATCH.
REQ-029 LATCH: pulse o_Latch_Totals; CLEAR: pulse o_Adder_Clear; then go to WAIT_TICK.
REQ-030 WAIT_TICK: on tick, or at once if Abort is set, pulse o_DAC_Send and o_Mult_Restart, set o_Harmonic=0, pulse o_Next_Sample, clear Abort, go to INIT.
REQ-031 A tick in any state other than WAIT_TICK SHALL set o_Overrun and Abort; Abort forces ADD_START, CHECK_MUTE, MULT and NEXT to go straight to DRAIN with no further adder start.
REQ-032 An adder start pulse issued in the same cycle as an abort tick SHALL still complete; DRAIN waits for it.
REQ-033 o_Harmonic SHALL NOT wrap: incrementing past 2^HARM_W-1 forces DRAIN.
REQ-034 At most one o_Adder_Start bit SHALL be high in any cycle.

Reset
REQ-035 Reset SHALL zero the timer, o_Harmonic, Abort, o_Overrun and all pulse outputs, and set the state to INIT; it takes effect mid-frame with no DAC send.
REQ-036 o_Overrun SHALL clear only on Reset.

Verification
REQ-037 NUM_ADDERS=2, count=4, ready stubs instant, no mute -> starts alternate bits 0,1,0,1,0 for harmonics 0..4; one o_Latch_Totals; o_DAC_Send exactly every 1000 cycles.
REQ-038 Comb_Muted asserted on harmonics 2 and 3 -> no start pulse for harmonics 2 and 3; o_Harmonic still reaches 5 before DRAIN.
REQ-039 i_Freq_Too_High asserted at harmonic 3 with count=50 -> DRAIN entered after harmonic 3; no start for harmonic 4.
REQ-040 Adder 1 stub held busy for 1200 cycles -> tick during ADD_START sets o_Overrun; DRAIN waits; DAC send follows CLEAR with no second tick.
REQ-041 NUM_ADDERS=4, count=7 -> start bits follow the sequence 1,2,4,8,1,2,4,8.
REQ-042 Reset pulsed in CHECK_MUTE -> all outputs 0 on the next cycle; no o_DAC_Send until the first tick after reset.
